counter_bn: RTL and testbench

- Parametrised successor of the team's 4-bit mode counter. Width, modulus and down-step are all configurable.
- Four modes: count up, count down, count down by STEP, and parallel load.
- Registered ripple-carry pulse on wrap, a load flag, and a zero flag.
- Intended as the general counter primitive for datapath and timer blocks. Cascadable through bn_rco.

---
 rtl/counter_bn.sv | 112 +++++++++++
 tb/tb_counter_bn.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/counter_bn.sv
// rtl/counter_bn.sv - parametrised up/down/step/load counter with rco, load and zero flags
// Optional feature: COUNTER_BN_SAT_EN selects saturating instead of wrapping behaviour.
module counter_bn #(
  parameter int unsigned WIDTH   = 4,
  parameter logic [31:0] MAX_VAL = 32'(2**WIDTH - 1),
  parameter logic [31:0] STEP    = 32'd3
) (
  input  logic             bn_clk,
  input  logic             bn_reset,
  input  logic             bn_enable,
  input  logic [1:0]       bn_mode,
  input  logic [WIDTH-1:0] bn_D,
  output logic [WIDTH-1:0] bn_Q,
  output logic             bn_load,
  output logic             bn_rco,
  output logic             bn_zero
);

  localparam logic [WIDTH:0] L_MAX  = {1'b0, MAX_VAL[WIDTH-1:0]};
  localparam logic [WIDTH:0] L_STEP = {1'b0, STEP[WIDTH-1:0]};

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic             r_load;
  logic             r_rco;

  logic [WIDTH:0]   w_q;
  logic [WIDTH:0]   w_d;
  logic [WIDTH:0]   w_next;
  logic [WIDTH-1:0] w_q_next;
  logic             w_load;
  logic             w_rco;

  // Arithmetic runs one bit wider so wrap sums and borrows never alias.
  assign w_q = ({1'b0, r_q} > L_MAX) ? L_MAX : {1'b0, r_q};
  assign w_d = ({1'b0, bn_D} > L_MAX) ? L_MAX : {1'b0, bn_D};

  always_comb begin
    w_next = w_q;
    w_load = 1'b0;
    w_rco  = 1'b0;
    if (bn_enable) begin
      case (bn_mode)
        MODE_UP: begin
          if (w_q == L_MAX) begin
            w_rco = 1'b1;
`ifdef COUNTER_BN_SAT_EN
            w_next = L_MAX;
`else
            w_next = '0;
`endif
          end else begin
            w_next = w_q + 1'b1;
          end
        end
        MODE_DOWN: begin
          if (w_q == '0) begin
            w_rco = 1'b1;
`ifdef COUNTER_BN_SAT_EN
            w_next = '0;
`else
            w_next = L_MAX;
`endif
          end else begin
            w_next = w_q - 1'b1;
          end
        end
        MODE_STEP: begin
          if (w_q >= L_STEP) begin
            w_next = w_q - L_STEP;
          end else begin
            w_rco = 1'b1;
`ifdef COUNTER_BN_SAT_EN
            w_next = '0;
`else
            w_next = w_q + L_MAX + 1'b1 - L_STEP;
`endif
          end
        end
        MODE_LOAD: begin
          w_next = w_d;
          w_load = 1'b1;
        end
        default: w_next = w_q;
      endcase
    end
  end

  assign w_q_next = (w_next > L_MAX) ? L_MAX[WIDTH-1:0] : w_next[WIDTH-1:0];

  always_ff @(posedge bn_clk or negedge bn_reset) begin
    if (!bn_reset) begin
      r_q    <= '0;
      r_load <= 1'b0;
      r_rco  <= 1'b0;
    end else begin
      r_q    <= w_q_next;
      r_load <= w_load;
      r_rco  <= w_rco;
    end
  end

  assign bn_Q    = r_q;
  assign bn_load = r_load;
  assign bn_rco  = r_rco;
  assign bn_zero = (r_q == '0);

endmodule

// File: tb/tb_counter_bn.sv
// tb/tb_counter_bn.sv - scoreboard bench for counter_bn (default and MAX_VAL=9 instances)
// Honours COUNTER_BN_SAT_EN so the reference model matches the build under test.
module tb_counter_bn;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] mode;
  logic [3:0] d;
  logic [3:0] q_a, q_b;
  logic       ld_a, ld_b, rco_a, rco_b, zero_a, zero_b;

  int n_cmp = 0;
  int n_err = 0;
  int mq_a  = 0;
  int mq_b  = 0;

  typedef struct {
    int q;
    bit ld;
    bit rc;
  } exp_t;
  exp_t sb[$];

`ifdef COUNTER_BN_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  counter_bn #(.WIDTH(4)) u_dut_a (
    .bn_clk(clk), .bn_reset(rst_n), .bn_enable(en), .bn_mode(mode), .bn_D(d),
    .bn_Q(q_a), .bn_load(ld_a), .bn_rco(rco_a), .bn_zero(zero_a)
  );

  counter_bn #(.WIDTH(4), .MAX_VAL(32'd9), .STEP(32'd3)) u_dut_b (
    .bn_clk(clk), .bn_reset(rst_n), .bn_enable(en), .bn_mode(mode), .bn_D(d),
    .bn_Q(q_b), .bn_load(ld_b), .bn_rco(rco_b), .bn_zero(zero_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic exp_t model(input int mx, input int st, input int q,
                                 input bit e, input logic [1:0] m, input int dv);
    exp_t r;
    r.q  = q;
    r.ld = 1'b0;
    r.rc = 1'b0;
    if (e) begin
      case (m)
        2'b00: if (q == mx) begin r.rc = 1'b1; r.q = SAT ? mx : 0; end else r.q = q + 1;
        2'b01: if (q == 0)  begin r.rc = 1'b1; r.q = SAT ? 0 : mx; end else r.q = q - 1;
        2'b10: if (q >= st) r.q = q - st;
               else begin r.rc = 1'b1; r.q = SAT ? 0 : (q + mx + 1 - st); end
        default: begin r.ld = 1'b1; r.q = (dv > mx) ? mx : dv; end
      endcase
    end
    return r;
  endfunction

  // Push both instances' expectations, clock once, then pop and compare in order.
  task automatic step(input bit e, input logic [1:0] m, input int dv, input string tag);
    exp_t ea, eb;
    ea = model(15, 3, mq_a, e, m, dv);
    eb = model(9, 3, mq_b, e, m, dv);
    sb.push_back(ea);
    sb.push_back(eb);
    mq_a = ea.q;
    mq_b = eb.q;
    en   = e;
    mode = m;
    d    = 4'(dv);
    @(posedge clk);
    #1;
    ea = sb.pop_front();
    check({tag, "_a_q"},    int'(q_a),    ea.q);
    check({tag, "_a_ld"},   int'(ld_a),   int'(ea.ld));
    check({tag, "_a_rco"},  int'(rco_a),  int'(ea.rc));
    check({tag, "_a_zero"}, int'(zero_a), int'(ea.q == 0));
    eb = sb.pop_front();
    check({tag, "_b_q"},    int'(q_b),    eb.q);
    check({tag, "_b_ld"},   int'(ld_b),   int'(eb.ld));
    check({tag, "_b_rco"},  int'(rco_b),  int'(eb.rc));
    check({tag, "_b_zero"}, int'(zero_b), int'(eb.q == 0));
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    mode  = 2'b00;
    d     = 4'd0;
    #3;
    check("por_q", int'(q_a), 0);
    check("por_zero", int'(zero_a), 1);
    check("por_flags", int'({ld_a, rco_a, ld_b, rco_b}), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Up wrap around 15
    step(1, 2'b11, 14, "ld14");
    check("ld14_const", int'(q_a), 14);
    check("ld14_clamp_b", int'(q_b), 9);
    for (int i = 0; i < 3; i++) step(1, 2'b00, 0, "up");
    if (!SAT) check("up_const", int'(q_a), 1);

    // Down by STEP with underflow
    step(1, 2'b11, 4, "ld4");
    for (int i = 0; i < 3; i++) step(1, 2'b10, 0, "stp");
    if (!SAT) check("stp_const", int'(q_a), 11);
    step(1, 2'b11, 2, "ld2");
    step(1, 2'b10, 0, "stp2");
    if (!SAT) check("stp2_const", int'(q_a), 15);

    // Decade wrap both directions and down from zero
    step(1, 2'b11, 12, "ld12");
    step(1, 2'b00, 0, "dec_up");
    step(1, 2'b01, 0, "dec_dn");
    step(1, 2'b11, 0, "ld0");
    step(1, 2'b01, 0, "dn0");

    // Enable low holds the count in every mode
    step(1, 2'b11, 7, "ld7");
    for (int i = 0; i < 5; i++) step(0, 2'(i), 3, "hold");
    check("hold_const", int'(q_a), 7);
    step(1, 2'b01, 0, "reen");
    check("reen_const", int'(q_a), 6);

    // Saturation bounds (wrap in the default build)
    step(1, 2'b11, 15, "ld15");
    step(1, 2'b00, 0, "top1");
    step(1, 2'b00, 0, "top2");
    step(1, 2'b11, 1, "ld1");
    step(1, 2'b10, 0, "stp1");
    step(1, 2'b11, 5, "ldh1");
    step(1, 2'b11, 6, "ldh2");

    // Asynchronous reset mid-cycle while Q=9
    step(1, 2'b11, 9, "ld9");
    en   = 1'b1;
    mode = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    check("rst_q_a", int'(q_a), 0);
    check("rst_q_b", int'(q_b), 0);
    check("rst_ld", int'({ld_a, ld_b}), 0);
    check("rst_rco", int'({rco_a, rco_b}), 0);
    check("rst_zero", int'({zero_a, zero_b}), 3);
    mq_a = 0;
    mq_b = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 2'b00, 0, "post_rst");

    for (int i = 0; i < 80; i++)
      step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
           int'($urandom_range(0, 15)), "rnd");

    check("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
